// File: rtl/rv32_icache_if.sv
// Bundle of the fetch-side instruction port and the backing memory read bus
// seen by the instruction cache. "slave" is the cache's view, "master" is the
// view of the environment (fetch stage plus memory) driving the cache.
interface rv32_icache_if;
  // Fetch-side instruction port
  logic        instr_read_in;
  logic [31:0] instr_address_in;
  logic        invalidate_in;
  logic [31:0] instr_read_value_out;
  logic        instr_ready_out;
  logic        instr_fault_out;
  // Backing memory read bus
  logic        mem_read_out;
  logic [31:0] mem_address_out;
  logic        mem_ready_in;
  logic [31:0] mem_read_value_in;
  logic        mem_fault_in;

  modport slave (
    input  instr_read_in,
    input  instr_address_in,
    input  invalidate_in,
    output instr_read_value_out,
    output instr_ready_out,
    output instr_fault_out,
    output mem_read_out,
    output mem_address_out,
    input  mem_ready_in,
    input  mem_read_value_in,
    input  mem_fault_in
  );

  modport master (
    output instr_read_in,
    output instr_address_in,
    output invalidate_in,
    input  instr_read_value_out,
    input  instr_ready_out,
    input  instr_fault_out,
    input  mem_read_out,
    input  mem_address_out,
    output mem_ready_in,
    output mem_read_value_in,
    output mem_fault_in
  );
endinterface

// File: rtl/rv32_icache.sv
// Direct-mapped read-only instruction cache. Hits answer fetch in the same
// cycle; misses refill one whole line word-by-word over a valid/ready bus.
// Bus faults are reported to fetch for one cycle and never cached.
// invalidate_in (fence.i) clears every valid bit.
module rv32_icache #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input logic           clk,
  input logic           reset,
  rv32_icache_if.slave  bus
);

  localparam int WORD_BITS   = $clog2(LINE_WORDS);
  localparam int OFFSET_BITS = WORD_BITS + 2;
  localparam int INDEX_BITS  = $clog2(LINES);
  localparam int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS;
  localparam int CNT_W       = (WORD_BITS > 0) ? WORD_BITS : 1;

  localparam logic [31:0]      LINE_MASK = 32'(LINE_WORDS * 4 - 1);
  localparam logic [31:0]      WORD_MASK = 32'(LINE_WORDS - 1);
  localparam logic [31:0]      NOP       = 32'h0000_0013;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REFILL = 2'd1;
  localparam logic [1:0] ST_FAULT  = 2'd2;

  // Storage
  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    valid_d;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES][LINE_WORDS];

  // Refill control
  logic [1:0]          state_q;
  logic [1:0]          state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [31:0]         base_q;
  logic [31:0]         base_d;
  logic                inv_seen_q;
  logic                inv_seen_d;
  logic                data_we_s;
  logic                tag_we_s;

  // Address decode of the fetch request and of the line being refilled
  logic [INDEX_BITS-1:0] req_idx_s;
  logic [TAG_BITS-1:0]   req_tag_s;
  logic [CNT_W-1:0]      req_word_s;
  logic [INDEX_BITS-1:0] fill_idx_s;
  logic [TAG_BITS-1:0]   fill_tag_s;
  logic                  hit_s;

  assign req_idx_s  = INDEX_BITS'(bus.instr_address_in >> OFFSET_BITS);
  assign req_tag_s  = TAG_BITS'(bus.instr_address_in >> (OFFSET_BITS + INDEX_BITS));
  assign req_word_s = CNT_W'((bus.instr_address_in >> 2) & WORD_MASK);
  assign fill_idx_s = INDEX_BITS'(base_q >> OFFSET_BITS);
  assign fill_tag_s = TAG_BITS'(base_q >> (OFFSET_BITS + INDEX_BITS));

  // Lookup only happens while idle; during refill or fault fetch is stalled.
  assign hit_s = ~reset & (state_q == ST_IDLE) & bus.instr_read_in &
                 valid_q[req_idx_s] & (tag_q[req_idx_s] == req_tag_s);

  // Bus request is a pure function of the registered FSM state and counter.
  assign bus.mem_read_out    = (state_q == ST_REFILL);
  assign bus.mem_address_out = base_q | (32'(cnt_q) << 2);

  // Fetch response: hit data, one-cycle fault report, otherwise a NOP and stall.
  always_comb begin
    bus.instr_ready_out      = 1'b0;
    bus.instr_fault_out      = 1'b0;
    bus.instr_read_value_out = NOP;
    if (reset) begin
      bus.instr_ready_out      = 1'b0;
      bus.instr_fault_out      = 1'b0;
      bus.instr_read_value_out = NOP;
    end else if (hit_s) begin
      bus.instr_ready_out      = 1'b1;
      bus.instr_fault_out      = 1'b0;
      bus.instr_read_value_out = data_q[req_idx_s][req_word_s];
    end else if (state_q == ST_FAULT) begin
      bus.instr_ready_out      = 1'b1;
      bus.instr_fault_out      = 1'b1;
      bus.instr_read_value_out = NOP;
    end else begin
      bus.instr_ready_out      = 1'b0;
      bus.instr_fault_out      = 1'b0;
      bus.instr_read_value_out = NOP;
    end
  end

  // Next-state logic for the miss/refill/fault FSM and the valid array.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    inv_seen_d = inv_seen_q;
    valid_d    = valid_q;
    data_we_s  = 1'b0;
    tag_we_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.instr_read_in && !hit_s) begin
          // The victim line is dropped up front so an aborted refill
          // never leaves stale data marked valid.
          base_d             = bus.instr_address_in & ~LINE_MASK;
          cnt_d              = '0;
          inv_seen_d         = 1'b0;
          valid_d[req_idx_s] = 1'b0;
          state_d            = ST_REFILL;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REFILL: begin
        // A fence.i seen at any point of the refill keeps the line invalid.
        if (bus.invalidate_in) begin
          inv_seen_d = 1'b1;
        end else begin
          inv_seen_d = inv_seen_q;
        end

        if (bus.mem_ready_in) begin
          if (bus.mem_fault_in) begin
            cnt_d   = '0;
            state_d = ST_FAULT;
          end else begin
            data_we_s = 1'b1;
            if (cnt_q == LAST_WORD) begin
              tag_we_s = 1'b1;
              if (!inv_seen_q) begin
                valid_d[fill_idx_s] = 1'b1;
              end else begin
                valid_d[fill_idx_s] = 1'b0;
              end
              cnt_d   = '0;
              state_d = ST_IDLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end else begin
          // Wait state: address and counter hold.
          state_d = ST_REFILL;
        end
      end

      ST_FAULT: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Invalidation wins over any same-cycle valid-set.
    if (bus.invalidate_in) begin
      valid_d = '0;
    end else begin
      valid_d = valid_d;
    end
  end

  // Control state with synchronous reset; reset discards any partial refill.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      base_q     <= 32'h0000_0000;
      inv_seen_q <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      inv_seen_q <= inv_seen_d;
      valid_q    <= valid_d;
    end
  end

  // Line data and tag arrays; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (data_we_s) begin
      data_q[fill_idx_s][cnt_q] <= bus.mem_read_value_in;
    end
    if (tag_we_s) begin
      tag_q[fill_idx_s] <= fill_tag_s;
    end
  end

endmodule

// File: tb/tb_rv32_icache.sv
// Self-checking bench for rv32_icache: directed scenarios followed by random
// fetches, checked against a line-level model of a direct-mapped cache and a
// procedural memory responder with random wait states and fault injection.
module tb_rv32_icache;

  localparam int LINES      = 16;
  localparam int LINE_WORDS = 4;
  localparam int LINE_BYTES = LINE_WORDS * 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  rv32_icache_if bus();

  rv32_icache #(.LINES(LINES), .LINE_WORDS(LINE_WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: which line tag each set holds, if any.
  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  function automatic int pick_wait(input int w);
    if (w >= 0) return w;
    return int'($urandom_range(0, 2));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.instr_read_in     = 1'b0;
    bus.invalidate_in     = 1'b0;
    bus.mem_ready_in      = 1'b0;
    bus.mem_fault_in      = 1'b0;
    bus.mem_read_value_in = 32'h0000_0000;
  endtask

  // One fetch of addr, acting as memory while the cache refills.
  // waits: wait cycles before every beat (-1 = random 0..2)
  // fault_beat: beat answered with a bus fault (-1 = none)
  // inv_beat: beat during which invalidate_in is pulsed (-1 = none)
  task automatic fetch(input logic [31:0] addr, input int waits, input int fault_beat,
                       input int inv_beat, input string name);
    int          idx;
    int unsigned tg;
    logic [31:0] base;
    bit          exp_hit;
    bit          done;
    bit          inv_fired;
    bit          faulted;
    int          beat;
    int          wcnt;
    int          wsum;
    int          cyc;
    int          exp_lat;

    idx       = int'((addr / LINE_BYTES) % LINES);
    tg        = addr / (LINE_BYTES * LINES);
    base      = addr - (addr % LINE_BYTES);
    exp_hit   = m_valid[idx] && (m_tag[idx] == tg);
    done      = 1'b0;
    inv_fired = 1'b0;
    faulted   = 1'b0;
    beat      = 0;
    cyc       = 0;
    wcnt      = pick_wait(waits);
    wsum      = wcnt;

    while (!done && cyc < 400) begin
      @(posedge clk);
      #1;
      bus.instr_read_in    = 1'b1;
      bus.instr_address_in = addr;
      bus.mem_ready_in     = 1'b0;
      bus.mem_fault_in     = 1'b0;
      bus.invalidate_in    = 1'b0;
      if (inv_fired && beat == LINE_WORDS) begin
        // Line was invalidated mid-refill: fetch withdraws, nothing answers.
        bus.instr_read_in = 1'b0;
        #1;
        chk({name, "_inv_noready"}, 32'(bus.instr_ready_out), 32'd0);
        done = 1'b1;
      end else begin
        if (bus.mem_read_out) begin
          chk({name, "_busaddr"}, bus.mem_address_out, base + 32'(4 * beat));
          if (beat == inv_beat && !inv_fired) begin
            bus.invalidate_in = 1'b1;
            inv_fired = 1'b1;
          end
          if (wcnt > 0) begin
            wcnt--;
          end else begin
            bus.mem_ready_in      = 1'b1;
            bus.mem_read_value_in = mem_word(base + 32'(4 * beat));
            bus.mem_fault_in      = (beat == fault_beat);
            faulted               = (beat == fault_beat);
            beat++;
            if (beat < LINE_WORDS && !faulted) begin
              wcnt = pick_wait(waits);
              wsum += wcnt;
            end
          end
        end
        #1;
        if (bus.instr_ready_out) begin
          done = 1'b1;
          chk({name, "_busidle"}, 32'(bus.mem_read_out), 32'd0);
          if (!exp_hit && fault_beat >= 0) begin
            exp_lat = 1 + (fault_beat + 1) + wsum;
            chk({name, "_fault"}, 32'(bus.instr_fault_out), 32'd1);
            chk({name, "_nop"}, bus.instr_read_value_out, NOP);
            m_valid[idx] = 1'b0;
          end else begin
            exp_lat = exp_hit ? 0 : (1 + LINE_WORDS + wsum);
            chk({name, "_fault"}, 32'(bus.instr_fault_out), 32'd0);
            chk({name, "_data"}, bus.instr_read_value_out, mem_word(addr & ~32'h3));
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
          end
          chk({name, "_latency"}, 32'(cyc), 32'(exp_lat));
        end else begin
          cyc++;
        end
      end
    end
    chk({name, "_completed"}, 32'(done), 32'd1);
    if (inv_fired) model_clear();
  endtask

  initial begin
    logic [31:0] a;
    int          fb;

    idle_inputs();
    bus.instr_address_in = 32'h0000_0000;
    model_clear();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("reset_ready", 32'(bus.instr_ready_out), 32'd0);
    chk("reset_fault", 32'(bus.instr_fault_out), 32'd0);
    chk("reset_memread", 32'(bus.mem_read_out), 32'd0);
    chk("reset_value", bus.instr_read_value_out, NOP);

    // 1: cold miss then same-line hits with no bus traffic
    fetch(32'h0000_0100, 0, -1, -1, "t1_cold");
    fetch(32'h0000_0104, 0, -1, -1, "t1_hit104");
    fetch(32'h0000_0108, 0, -1, -1, "t1_hit108");
    fetch(32'h0000_010C, 0, -1, -1, "t1_hit10c");

    // 2: three wait states before every beat
    fetch(32'h0000_0500, 3, -1, -1, "t2_wait");

    // 3: conflicting lines thrash; a different set survives
    fetch(32'h0000_0040, 0, -1, -1, "t3_load40");
    for (int i = 0; i < 3; i++) begin
      fetch(32'h0000_0000, 0, -1, -1, "t3_conf000");
      fetch(32'h0000_0100, 0, -1, -1, "t3_conf100");
    end
    fetch(32'h0000_0040, 0, -1, -1, "t3_hit40");

    // 4: fault on beat 2, then the same address refills again
    fetch(32'h0000_0200, 0, 2, -1, "t4_fault");
    fetch(32'h0000_0200, 0, -1, -1, "t4_refetch");

    // 5: fence.i during refill leaves everything invalid
    fetch(32'h0000_0100, 0, -1, -1, "t5_load100");
    fetch(32'h0000_0300, 0, -1, 1, "t5_inv");
    fetch(32'h0000_0300, 0, -1, -1, "t5_miss300");
    fetch(32'h0000_0100, 0, -1, -1, "t5_miss100");

    // 6: reset in the middle of a refill
    @(posedge clk);
    #1;
    idle_inputs();
    bus.instr_read_in    = 1'b1;
    bus.instr_address_in = 32'h0000_0340;
    for (int b = 0; b < 2; b++) begin
      @(posedge clk);
      #1;
      chk("t6_busaddr", bus.mem_address_out, 32'h0000_0340 + 32'(4 * b));
      bus.mem_ready_in      = 1'b1;
      bus.mem_read_value_in = mem_word(32'h0000_0340 + 32'(4 * b));
    end
    @(posedge clk);
    #1;
    bus.mem_ready_in = 1'b0;
    chk("t6_busreq", 32'(bus.mem_read_out), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.instr_read_in = 1'b0;
    #1;
    chk("t6_memread_off", 32'(bus.mem_read_out), 32'd0);
    chk("t6_ready_off", 32'(bus.instr_ready_out), 32'd0);
    model_clear();
    fetch(32'h0000_0100, 0, -1, -1, "t6_miss100");
    fetch(32'h0000_0000, 0, -1, -1, "t6_zero");
    fetch(32'h0000_0348, 0, -1, -1, "t6_partial");

    // Random fetches with random wait states and occasional faults
    for (int n = 0; n < 60; n++) begin
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = a | 32'hF000_0000;
      fb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      fetch(a, -1, fb, -1, "rnd");
    end

    @(posedge clk);
    #1;
    idle_inputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
